// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the sqrt datapath scheduler.
package sqrt_sched_pkg;

    // Scheduler phases; the encoding is driven straight onto dp_state.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_ITER = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] ROOT_ERR = 8'hFF;

endpackage

// File: rtl/sqrt_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the pointer, wrapping.
module sqrt_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           en_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_idx_o,
    output logic [IDW-1:0] ptr_nxt_o
);

    // Scan N positions starting at the pointer; the extra bit absorbs the wrap for any N.
    always_comb begin
        logic           found;
        logic [IDW:0]   pos;
        logic [IDW:0]   nxt;
        gnt_o     = '0;
        gnt_idx_o = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        pos       = '0;
        nxt       = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr_i} + (IDW+1)'(i);
            pos = (pos >= (IDW+1)'(N)) ? (pos - (IDW+1)'(N)) : pos;
            if (en_i && !found && req_i[pos[IDW-1:0]]) begin
                found     = 1'b1;
                gnt_idx_o = pos[IDW-1:0];
            end else begin
                found = found;
            end
        end
        if (found) begin
            gnt_o[gnt_idx_o] = 1'b1;
            nxt              = {1'b0, gnt_idx_o} + (IDW+1)'(1);
            ptr_nxt_o        = (nxt == (IDW+1)'(N)) ? '0 : nxt[IDW-1:0];
        end else begin
            ptr_nxt_o = ptr_i;
        end
    end

endmodule

// File: rtl/sqrt_sched.sv
// sqrt_sched: shares one odd-accumulation sqrt datapath among N round-robin requesters.
// Define SQRT_SCHED_TIMEOUT_EN to build the ITER watchdog (root 8'hFF, rsp_err=1 on expiry).
module sqrt_sched
    import sqrt_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_ITER = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req_valid,
    input  logic [8*N-1:0]      req_data,
    output logic [N-1:0]        req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_root,
    output logic                rsp_err,
    output logic [7:0]          dp_a,
    output logic [1:0]          dp_state,
    output logic                dp_en_a,
    output logic                dp_ld_add,
    output logic                dp_en_sq,
    output logic                dp_en_delta,
    output logic                dp_en_out,
    input  logic                dp_greater,
    input  logic [7:0]          dp_sqrt
);

    state_e              state_q;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      ptr_d;
    logic [DATA_W-1:0]   dp_a_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [DATA_W-1:0]   rsp_root_q;
    logic                rsp_valid_q;
    logic [N-1:0]        gnt_s;
    logic [IDW-1:0]      gnt_idx_s;
    logic                gnt_any_s;
    logic                step_s;
    logic [DATA_W-1:0]   op_sel_s;

`ifdef SQRT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_ITER + 1);
    logic [CNT_W-1:0]    iter_cnt_q;
    logic [CNT_W-1:0]    iter_cnt_d;
    logic                rsp_err_q;
    logic                timeout_s;

    assign iter_cnt_d = iter_cnt_q + CNT_W'(1);
    assign timeout_s  = (iter_cnt_d == CNT_W'(MAX_ITER));
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

    sqrt_rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .en_i      (state_q == S_IDLE),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .ptr_nxt_o (ptr_d)
    );

    assign gnt_any_s = |gnt_s;

    // Only the granted requester's operand lane is forwarded.
    always_comb begin
        op_sel_s = '0;
        for (int i = 0; i < N; i++) begin
            op_sel_s = (gnt_idx_s == IDW'(i)) ? req_data[i*DATA_W +: DATA_W] : op_sel_s;
        end
    end

    // The step strobe must follow the registered compare in the same cycle.
    assign step_s      = (state_q == S_ITER) && !dp_greater;
    assign req_ready   = gnt_s;
    assign dp_state    = state_q;
    assign dp_a        = dp_a_q;
    assign dp_en_a     = (state_q == S_LOAD);
    assign dp_ld_add   = step_s;
    assign dp_en_sq    = step_s;
    assign dp_en_delta = step_s;
    assign dp_en_out   = (state_q == S_DONE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_root    = rsp_root_q;

    // Scheduler FSM with grant capture, result capture and response handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            dp_a_q      <= '0;
            rsp_id_q    <= '0;
            rsp_root_q  <= '0;
            rsp_valid_q <= 1'b0;
`ifdef SQRT_SCHED_TIMEOUT_EN
            iter_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any_s) begin
                        dp_a_q   <= op_sel_s;
                        rsp_id_q <= gnt_idx_s;
                        ptr_q    <= ptr_d;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_q <= S_ITER;
`ifdef SQRT_SCHED_TIMEOUT_EN
                    iter_cnt_q <= '0;
`endif
                end
                S_ITER: begin
                    if (dp_greater) begin
                        rsp_root_q  <= dp_sqrt;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`ifdef SQRT_SCHED_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (timeout_s) begin
                        rsp_root_q  <= ROOT_ERR;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        iter_cnt_q  <= iter_cnt_d;
`endif
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_sched.sv
// Self-checking bench for sqrt_sched: odd-accumulation datapath model, transaction-level
// reference checked every cycle, and directed vectors with hand-computed expectations.
module tb_sqrt_sched;
    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_ITER = 17;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [7:0]     rsp_root;
    logic           rsp_err;
    logic [7:0]     dp_a;
    logic [1:0]     dp_state;
    logic           dp_en_a, dp_ld_add, dp_en_sq, dp_en_delta, dp_en_out;
    logic           dp_greater;
    logic [7:0]     dp_sqrt;
    logic           force_low;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int g_id[$];
    int g_cyc[$];
    int r_id[$];
    int r_root[$];
    int r_err[$];
    int r_lat[$];
    int r_steps[$];
    int r_cyc[$];

    always #5 clk = ~clk;

    sqrt_sched #(.N(N), .IDW(IDW), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_root(rsp_root), .rsp_err(rsp_err), .dp_a(dp_a),
        .dp_state(dp_state), .dp_en_a(dp_en_a), .dp_ld_add(dp_ld_add),
        .dp_en_sq(dp_en_sq), .dp_en_delta(dp_en_delta), .dp_en_out(dp_en_out),
        .dp_greater(dp_greater), .dp_sqrt(dp_sqrt)
    );

    // Behavioural datapath: square starts at 1, delta at 3; greater = number < square (registered).
    logic [7:0]  dm_num;
    logic [15:0] dm_sq, dm_delta;
    logic        dm_gt;
    logic [7:0]  nn;
    logic [15:0] ns, nd;
    assign nn = dp_en_a ? dp_a : dm_num;
    assign ns = dp_en_sq ? (dm_sq + dm_delta) : dm_sq;
    assign nd = dp_en_delta ? (dm_delta + 16'd2) : dm_delta;
    always @(posedge clk) begin
        if (dp_state == 2'b00) begin
            dm_num   <= 8'd0;
            dm_sq    <= 16'd1;
            dm_delta <= 16'd3;
            dm_gt    <= 1'b0;
        end else begin
            dm_num   <= nn;
            dm_sq    <= ns;
            dm_delta <= nd;
            dm_gt    <= force_low ? 1'b0 : ({8'd0, nn} < ns);
        end
    end
    assign dp_greater = dm_gt;
    assign dp_sqrt    = dm_delta[8:1] - 8'd1;

    function automatic int isqrt(input int a);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expire(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: idle / busy(countdown) / responding, checked on every falling edge.
    int  phase = 0, m_ptr = 0, m_cnt = 0, m_lat = 0, m_steps = 0, m_id = 0, m_root = 0, m_err = 0, m_a = 0;
    int  exp_g, last_gcyc = 0, step_acc = 0, lat_m = 0, steps_m = 0;
    bit  rst_prev = 1'b0, rv_prev = 1'b0;
    logic [N-1:0] exp_rr;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            phase   = 0;
            m_ptr   = 0;
            rv_prev = 1'b0;
        end else begin
            if (rst_prev) begin
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_rsp_root", rsp_root, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_dp_a", dp_a, 0);
                chk("rst_dp_state", dp_state, 0);
            end
            if (phase == 1) begin
                m_cnt++;
                if (m_cnt >= m_lat) phase = 2;
            end
            if (phase == 0) begin
                exp_g = -1;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (exp_g < 0 && req_valid[j]) exp_g = j;
                end
                exp_rr = '0;
                if (exp_g >= 0) exp_rr[exp_g] = 1'b1;
                chk("idle_req_ready", req_ready, exp_rr);
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_dp_state", dp_state, 0);
                chk("idle_step", {dp_ld_add, dp_en_sq, dp_en_delta}, 0);
                chk("idle_en", {dp_en_a, dp_en_out}, 0);
                if (exp_g >= 0) begin
                    m_id    = exp_g;
                    m_a     = req_data[exp_g*8 +: 8];
                    m_root  = isqrt(m_a);
                    m_steps = m_root;
                    m_lat   = m_root + 3;
                    m_err   = 0;
                    if (force_low) begin
                        m_root  = 255;
                        m_steps = MAX_ITER;
                        m_lat   = MAX_ITER + 2;
                        m_err   = 1;
                    end
                    m_ptr = (exp_g + 1) % N;
                    m_cnt = 0;
                    phase = 1;
                end
            end else if (phase == 1) begin
                chk("busy_req_ready", req_ready, 0);
                chk("busy_rsp_valid", rsp_valid, 0);
                chk("busy_dp_a", dp_a, m_a);
                chk("busy_en_a", dp_en_a, (m_cnt == 1));
                chk("busy_step", {dp_ld_add, dp_en_sq, dp_en_delta},
                    (m_cnt >= 2 && m_cnt <= 1 + m_steps) ? 3'b111 : 3'b000);
                chk("busy_en_out", dp_en_out, 0);
                chk("busy_dp_state", dp_state, (m_cnt == 1) ? 1 : 2);
            end else begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_root", rsp_root, m_root);
                chk("rsp_err", rsp_err, m_err);
                chk("rsp_req_ready", req_ready, 0);
                chk("rsp_step", {dp_ld_add, dp_en_sq, dp_en_delta}, 0);
                chk("rsp_en_out", dp_en_out, 1);
                chk("rsp_dp_state", dp_state, 3);
                if (rsp_ready) phase = 0;
            end
            // Transaction log measured from the DUT pins.
            for (int k = 0; k < N; k++) begin
                if (req_ready[k]) begin
                    g_id.push_back(k);
                    g_cyc.push_back(cyc);
                    last_gcyc = cyc;
                    step_acc  = 0;
                end
            end
            if (dp_ld_add) step_acc++;
            if (rsp_valid && !rv_prev) begin
                lat_m   = cyc - last_gcyc;
                steps_m = step_acc;
            end
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(int'(rsp_id));
                r_root.push_back(int'(rsp_root));
                r_err.push_back(int'(rsp_err));
                r_lat.push_back(lat_m);
                r_steps.push_back(steps_m);
                r_cyc.push_back(cyc);
            end
            rv_prev = rsp_valid;
        end
        rst_prev = reset;
    end

    task automatic wait_grant(input int id);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (req_ready[id] && !reset) break;
            n++;
        end
        if (n >= 100) expire("wait_grant");
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (r_root.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (r_root.size() < target) expire("wait_rsp");
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input int a);
        req_data[id*8 +: 8] = 8'(a);
        req_valid[id]       = 1'b1;
        wait_grant(id);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Global time bound in case a wait loop itself misbehaves.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time bound reached");
        $fatal(1, "time bound");
    end

    int r0, g0, n;
    int exp_gs[5] = '{0, 1, 2, 3, 0};
    int exp_rs[5] = '{2, 3, 5, 10, 2};
    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1; force_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("model_isqrt16", isqrt(16), 4);
        chk("model_isqrt255", isqrt(255), 15);
        chk("model_isqrt48", isqrt(48), 6);

        // Single request a=16: 4 steps, root 4, valid 7 cycles after grant.
        r0 = r_root.size();
        send(0, 16);
        wait_rsp(r0 + 1);
        chk("a16_root", r_root[r0], 4);
        chk("a16_id", r_id[r0], 0);
        chk("a16_lat", r_lat[r0], 7);
        chk("a16_steps", r_steps[r0], 4);

        // Boundary operands.
        r0 = r_root.size();
        send(0, 0);
        wait_rsp(r0 + 1);
        chk("a0_root", r_root[r0], 0);
        chk("a0_lat", r_lat[r0], 3);
        chk("a0_steps", r_steps[r0], 0);
        r0 = r_root.size();
        send(0, 255);
        wait_rsp(r0 + 1);
        chk("a255_root", r_root[r0], 15);
        chk("a255_lat", r_lat[r0], 18);
        chk("a255_steps", r_steps[r0], 15);

        // All requesters held valid: grants 0,1,2,3,0.
        do_reset();
        g0 = g_id.size();
        r0 = r_root.size();
        req_data = {8'd100, 8'd25, 8'd9, 8'd4};
        req_valid = 4'hF;
        n = 0;
        while (g_id.size() < g0 + 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (g_id.size() < g0 + 5) expire("rr_grants");
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp(r0 + 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant_order", g_id[g0+k], exp_gs[k]);
            chk("rr_root", r_root[r0+k], exp_rs[k]);
            chk("rr_rsp_id", r_id[r0+k], exp_gs[k]);
        end

        // Back-pressure: response held for 5 cycles, next grant the cycle after handshake.
        do_reset();
        rsp_ready = 1'b0;
        g0 = g_id.size();
        r0 = r_root.size();
        req_data[15:8]  = 8'd36;
        req_data[23:16] = 8'd64;
        req_valid = 4'b0110;
        wait_grant(1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) expire("bp_rsp_valid");
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_id", rsp_id, 1);
            chk("bp_hold_root", rsp_root, 6);
            chk("bp_no_grant", req_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_grant(2);
        wait_rsp(r0 + 2);
        chk("bp_root36", r_root[r0], 6);
        chk("bp_root64", r_root[r0+1], 8);
        chk("bp_id2", r_id[r0+1], 2);
        chk("bp_grant_after_hs", g_cyc[g0+1], r_cyc[r0] + 1);

        // Reset mid-ITER discards the transaction and restarts the pointer.
        do_reset();
        req_data[7:0] = 8'd200;
        req_valid[0]  = 1'b1;
        wait_grant(0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        r0 = r_root.size();
        @(posedge clk);
        #1;
        reset = 1'b0;
        g0 = g_id.size();
        req_data[7:0]  = 8'd49;
        req_data[15:8] = 8'd4;
        req_valid = 4'b0011;
        wait_grant(0);
        wait_grant(1);
        wait_rsp(r0 + 2);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_first_grant", g_id[g0], 0);
        chk("rst_root49", r_root[r0], 7);
        chk("rst_root4", r_root[r0+1], 2);
        chk("rst_rsp_count", r_root.size(), r0 + 2);

`ifdef SQRT_SCHED_TIMEOUT_EN
        // Watchdog: greater never rises, 17 ITER cycles then error response.
        force_low = 1'b1;
        r0 = r_root.size();
        send(0, 9);
        wait_rsp(r0 + 1);
        force_low = 1'b0;
        chk("to_root", r_root[r0], 255);
        chk("to_err", r_err[r0], 1);
        chk("to_lat", r_lat[r0], MAX_ITER + 2);
        chk("to_steps", r_steps[r0], MAX_ITER);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sqrt_sched.md
Name: sqrt_sched

Overview:
- Shares one integer-square-root datapath (odd-number accumulation: square += delta, delta += 2) among N requesters.
- Arbitrates requesters round-robin and sequences the datapath control lines through clear/load/iterate/done.
- Captures the root and returns it on a valid/ready response channel tagged with the requester id.
- Sits between client blocks and the sqrt datapath instance.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must equal clog2(N).
- MAX_ITER, 17, ITER-cycle limit used only by the optional watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  N  per-requester request valid
- req_data  in  8*N  operand for requester i, in bits [8i+7:8i]
- req_ready  out  N  one-hot; accept pulse for the granted requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_id  out  IDW  requester index of the result
- rsp_root  out  8  floor(sqrt(operand))
- rsp_err  out  1  watchdog timeout flag
- dp_a  out  8  operand to the datapath
- dp_state  out  2  datapath phase; 00 clears the datapath
- dp_en_a  out  1  load operand
- dp_ld_add  out  1  step strobe
- dp_en_sq  out  1  square += delta
- dp_en_delta  out  1  delta += 2
- dp_en_out  out  1  result phase
- dp_greater  in  1  registered flag: number < square
- dp_sqrt  in  8  datapath root; valid when dp_greater=1

Behaviour:
- This block: reset reset, synchronous, active-high; clock clk.
- Reset values: FSM=IDLE, RR pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_root=0, rsp_err=0, dp_a=0.
- FSM states: IDLE=00, LOAD=01, ITER=10, DONE=11. dp_state always equals the FSM encoding.
- IDLE: if any req_valid is set, grant the first set bit at or after the RR pointer, wrapping.
  - Pulse req_ready[g] for that one cycle.
  - Latch the operand into dp_a and g into rsp_id.
  - Set the pointer to (g+1) mod N. Go to LOAD.
  - With no request, stay in IDLE.
- LOAD: dp_en_a=1. Go to ITER.
- ITER: step = ~dp_greater. dp_ld_add, dp_en_sq and dp_en_delta all equal step.
  - When dp_greater=1, latch rsp_root=dp_sqrt, rsp_err=0, and go to DONE.
  - ITER lasts isqrt(a)+1 cycles.
- DONE: rsp_valid=1 and dp_en_out=1.
  - On rsp_valid & rsp_ready, drop rsp_valid and return to IDLE.
  - A grant can occur no earlier than the cycle after the handshake.
  - rsp_id, rsp_root and rsp_err stay stable while rsp_valid is high.
- Latency: from grant cycle to first rsp_valid cycle is isqrt(a)+3 cycles (a=0 gives 3; a=255 gives 18).
- Requests arriving while the FSM is busy wait; req_valid must be held until req_ready.
- Reset mid-operation: the transaction is discarded with no response. Outputs return to reset values and the datapath is cleared via dp_state=00.
- req_data for non-granted requesters is ignored.

Optional Feature:
- Macro: SQRT_SCHED_TIMEOUT_EN
- Defined:
  - An ITER cycle counter, cleared in LOAD, counts each ITER cycle.
  - If the counter reaches MAX_ITER with dp_greater still 0, go to DONE with rsp_root=8'hFF and rsp_err=1.
- Undefined: no counter is built; rsp_err is tied to 0; ITER waits indefinitely for dp_greater.

Decomposition:
- Package sqrt_sched_pkg:
  - State encodings S_IDLE/S_LOAD/S_ITER/S_DONE (2-bit, matching the dp_state codes).
  - DATA_W=8 and ROOT_ERR=8'hFF.
- Sub-module sqrt_rr_arbiter:
  - Inputs: N-bit request vector, pointer, grant enable.
  - Outputs: one-hot grant, grant index, next pointer.
  - Purely combinational; the pointer register lives in sqrt_sched.

Test Plan:
- Single request, req 0, a=16 with a behavioural datapath model -> 4 step cycles, rsp_root=4, rsp_id=0, rsp_valid 7 cycles after grant.
- a=0 -> no step strobes, rsp_root=0 after 3 cycles; a=255 -> 15 steps, rsp_root=15 after 18 cycles.
- All 4 requesters valid continuously, operands 4,9,25,100 -> grants in order 0,1,2,3,0; roots 2,3,5,10 with matching rsp_id.
- rsp_ready held low for 5 cycles in DONE -> rsp_valid, rsp_id and rsp_root stable, no new grant; grant follows the cycle after ready.
- Reset asserted mid-ITER on a=200 -> next cycle IDLE, no response; a fresh request a=49 returns 7 and the pointer restarts from 0.
- With SQRT_SCHED_TIMEOUT_EN and dp_greater forced low -> after 17 ITER cycles, rsp_root=8'hFF and rsp_err=1.
